axis_byte_deserializer: RTL and testbench
=========================================

# axis_byte_deserializer

Receive-side AXI-stream stage that consumes the 8-bit byte stream produced by the team's 64-bit-to-byte AXI master (data/valid/ready/last) and reassembles each frame into a 64-bit word. The first byte received is placed in bits [7:0]. The completed word is held on a parallel output port until the consumer acknowledges it. It sits directly downstream of the serializer and is the loopback partner for its benches.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: idle cycles allowed inside a partial frame before it is aborted (used only with the timeout feature).

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- data  in  8  AXI-stream byte
- valid  in  1  upstream byte valid
- last  in  1  upstream marks final byte of frame
- ready  out  1  block can accept a byte
- out_data  out  64  assembled word; byte k of the frame in bits [8k+7:8k]
- out_count  out  4  number of bytes in the held word, 1..8
- out_valid  out  1  word held and available
- out_err  out  1  held word is a length error (8 bytes without last)
- out_ack  in  1  consumer takes the word

## Operation
- Two states:
  - COLLECT: ready=1, accumulating bytes.
  - HOLD: ready=0, out_valid=1.
- Byte accepted on a rising edge with valid && ready. It is written to lane byte_cnt, and byte_cnt increments (3-bit index, 4-bit count).
- Frame end: the accepted byte has last=1, or it is the 8th byte.
  - On frame end, go to HOLD with out_count = byte_cnt+1.
  - Lanes not written are 0.
  - out_err=1 only when the 8th byte arrives with last=0.
- Bytes after an out_err frame start a new frame; there is no resynchronisation to last.
- HOLD: outputs are frozen. out_ack=1 at an edge returns the block to COLLECT, clears out_valid, out_err, byte_cnt and the assembly register.
- out_ack while in COLLECT is ignored.
- data and last are ignored unless valid && ready.
- Reset (reset_n=0 at an edge) gives COLLECT with:
  - ready=1, out_valid=0, out_err=0, out_count=0;
  - out_data=0, byte_cnt=0.
- A partial frame or held word in flight at reset is discarded.

## Timing
- All outputs are registered.
- ready is 1 from the first edge after reset release.
- The edge that accepts the final byte also sets out_valid=1 and ready=0. Latency is 0 cycles after that edge.
- The edge with out_ack=1 in HOLD sets out_valid=0 and ready=1. The next byte can be accepted at the following edge.
- Minimum period per 8-byte frame: 8 accept edges plus 1 ack edge.
- Upstream stalls (valid=0) and gaps do not alter the partial frame, except as described under timeout.

## Configuration
- AXIS_DESER_TIMEOUT_EN defined:
  - A counter runs while in COLLECT with byte_cnt>0 and valid=0. It resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, the partial frame is delivered in HOLD with out_err=1 and out_count equal to the bytes received.
- Not defined: no counter is built, a partial frame waits indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package axis_pkg holds:
  - AXIS_BYTE_W=8, AXIS_WORD_BYTES=8, AXIS_WORD_W=64;
  - the state enum {COLLECT, HOLD}.
- The serializer uses the same constants.
- One sub-module, axis_idle_timer: a counter with clear, enable and expired outputs. It is instantiated only under AXIS_DESER_TIMEOUT_EN.

## Test plan
- **Full frame:** send 01..08 with last on 08, ready respected, out_ack held 0.
  - Expect out_data=0807060504030201, out_count=8, out_err=0, ready=0.
  - After one out_ack pulse: out_valid=0, ready=1.
- **Short frame:** send A1 B2 C3 D4 with last on D4.
  - Expect out_data=00000000D4C3B2A1, out_count=4, out_err=0.
- **Upstream gaps:** send 11..88 with valid low for 5 cycles after the 3rd byte.
  - Expect out_data=8877665544332211; no byte is lost or duplicated.
- **Backpressure in HOLD:** after a frame, drive valid=1 with FF for 4 cycles before out_ack.
  - Expect ready=0 throughout and the held word unchanged.
  - FF is accepted only after the ack edge.
- **Length error:** send 8 bytes with last=0.
  - Expect out_err=1, out_count=8.
  - After ack, a following 2-byte frame gives out_count=2, out_err=0.
- **Reset mid-frame:** reset after 3 bytes, then send a new 1-byte frame with last.
  - Expect all outputs at reset values during reset.
  - Expect out_data=00000000000000XX, out_count=1.
  - With AXIS_DESER_TIMEOUT_EN: 2 bytes then idle for 16 cycles gives out_err=1, out_count=2.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-stream byte/word constants and the deserializer state type,
// common to the 64-bit-to-byte serializer and its receive-side partner.
package axis_pkg;

    localparam int AXIS_BYTE_W     = 8;
    localparam int AXIS_WORD_BYTES = 8;
    localparam int AXIS_WORD_W     = AXIS_BYTE_W * AXIS_WORD_BYTES;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } deser_state_e;

endpackage

// File: rtl/axis_idle_timer.sv
// Saturating idle counter: clear wins, counts while enabled, flags once LIMIT is reached.
module axis_idle_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    assign expired_o = (count_q == CW'(LIMIT));

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/axis_byte_deserializer.sv
// Reassembles an AXI-stream byte frame (first byte in bits [7:0]) into a held 64-bit word.
// Optional partial-frame abort on upstream idle: define AXIS_DESER_TIMEOUT_EN.
module axis_byte_deserializer
    import axis_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [AXIS_BYTE_W-1:0] data,
    input  logic                   valid,
    input  logic                   last,
    output logic                   ready,
    output logic [AXIS_WORD_W-1:0] out_data,
    output logic [3:0]             out_count,
    output logic                   out_valid,
    output logic                   out_err,
    input  logic                   out_ack
);

    deser_state_e           state_q;
    logic [3:0]             byteCnt_q;
    logic [AXIS_WORD_W-1:0] word_q;
    logic [3:0]             outCount_q;
    logic                   outErr_q;
    logic                   outValid_q;
    logic                   ready_q;

    logic       acceptByte;
    logic       frameEnd;
    logic [2:0] byteLane;
    logic       timeoutHit;

    assign acceptByte = valid && ready_q;
    assign byteLane   = byteCnt_q[2:0];
    assign frameEnd   = last || (byteCnt_q == 4'(AXIS_WORD_BYTES - 1));

`ifdef AXIS_DESER_TIMEOUT_EN
    axis_idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  ((state_q != COLLECT) || acceptByte),
        .enable_i ((state_q == COLLECT) && (byteCnt_q != 4'd0) && !valid),
        .expired_o(timeoutHit)
    );
`else
    // No idle timer here: a partial frame waits for its remaining bytes forever.
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= COLLECT;
            byteCnt_q  <= '0;
            word_q     <= '0;
            outCount_q <= '0;
            outErr_q   <= 1'b0;
            outValid_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (acceptByte) begin
                        word_q[{byteLane, 3'b000} +: AXIS_BYTE_W] <= data;
                        byteCnt_q <= byteCnt_q + 4'd1;
                        if (frameEnd) begin
                            state_q    <= HOLD;
                            ready_q    <= 1'b0;
                            outValid_q <= 1'b1;
                            outCount_q <= byteCnt_q + 4'd1;
                            outErr_q   <= !last;
                        end
                    end else if (timeoutHit) begin
                        // Abandoned partial frame is delivered as-is, flagged as an error.
                        state_q    <= HOLD;
                        ready_q    <= 1'b0;
                        outValid_q <= 1'b1;
                        outCount_q <= byteCnt_q;
                        outErr_q   <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ack) begin
                        state_q    <= COLLECT;
                        ready_q    <= 1'b1;
                        outValid_q <= 1'b0;
                        outErr_q   <= 1'b0;
                        outCount_q <= '0;
                        byteCnt_q  <= '0;
                        word_q     <= '0;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign out_data  = word_q;
    assign out_count = outCount_q;
    assign out_valid = outValid_q;
    assign out_err   = outErr_q;

endmodule

// File: tb/tb_axis_byte_deserializer.sv
// Randomized and directed bench for axis_byte_deserializer against a frame-level reference model.
// Exercises the idle-abort path when AXIS_DESER_TIMEOUT_EN is defined.
module tb_axis_byte_deserializer;

    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  data;
    logic        valid;
    logic        last;
    logic        ready;
    logic [63:0] out_data;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_err;
    logic        out_ack;

    int total = 0;
    int bad   = 0;

    logic [7:0] frameQ[$];

    axis_byte_deserializer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data     (data),
        .valid    (valid),
        .last     (last),
        .ready    (ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_err  (out_err),
        .out_ack  (out_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: byte k of the frame lands in bits [8k+7:8k], unused lanes are zero.
    function automatic logic [63:0] modelWord();
        logic [63:0] w = '0;
        for (int k = 0; k < frameQ.size(); k++) begin
            w = w | (64'(frameQ[k]) << (8 * k));
        end
        return w;
    endfunction

    task automatic sendByte(input logic [7:0] b, input logic isLast);
        int waitCycles = 0;
        out_ack = 1'b0;
        valid   = 1'b1;
        data    = b;
        last    = isLast;
        while (!ready && waitCycles < 64) begin
            tick();
            waitCycles++;
        end
        if (!ready) checkOutput("readyWait", 64'(ready), 64'd1);
        tick();
        valid = 1'b0;
        data  = 8'($urandom);
        last  = 1'($urandom);
    endtask

    task automatic applyStimulus(input logic lastOnFinal, input int maxGap);
        for (int i = 0; i < frameQ.size(); i++) begin
            repeat ($urandom_range(maxGap, 0)) begin
                valid   = 1'b0;
                data    = 8'($urandom);
                last    = 1'($urandom);
                out_ack = 1'($urandom);
                tick();
            end
            sendByte(frameQ[i], lastOnFinal && (i == frameQ.size() - 1));
        end
    endtask

    task automatic fillRandom(input int n);
        frameQ.delete();
        for (int i = 0; i < n; i++) frameQ.push_back(8'($urandom));
    endtask

    task automatic expectHold(input string tag, input logic [63:0] word, input int cnt, input logic err);
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ".ready"}, 64'(ready), 64'd0);
        checkOutput({tag, ".data"}, out_data, word);
        checkOutput({tag, ".count"}, 64'(out_count), 64'(cnt));
        checkOutput({tag, ".err"}, 64'(out_err), 64'(err));
    endtask

    task automatic doAck(input string tag);
        valid   = 1'b0;
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checkOutput({tag, ".ackValid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ".ackReady"}, 64'(ready), 64'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".ready"}, 64'(ready), 64'd1);
        checkOutput({tag, ".valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, ".err"}, 64'(out_err), 64'd0);
        checkOutput({tag, ".count"}, 64'(out_count), 64'd0);
        checkOutput({tag, ".data"}, out_data, 64'd0);
    endtask

    initial begin
        logic [63:0] heldWord;
        logic        lastFinal;
        int          waited;

        reset_n = 1'b0;
        valid   = 1'b0;
        last    = 1'b0;
        data    = 8'h00;
        out_ack = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        checkResetState("reset");
        reset_n = 1'b1;
        tick();
        checkOutput("postReset.ready", 64'(ready), 64'd1);

        frameQ = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        applyStimulus(1'b1, 0);
        expectHold("full", 64'h0807060504030201, 8, 1'b0);
        doAck("full");

        frameQ = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        applyStimulus(1'b1, 0);
        expectHold("short", 64'h00000000D4C3B2A1, 4, 1'b0);
        doAck("short");

        frameQ = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                valid = 1'b0;
                repeat (5) tick();
            end
            sendByte(frameQ[i], i == 7);
        end
        expectHold("gaps", 64'h8877665544332211, 8, 1'b0);

        heldWord = modelWord();
        valid = 1'b1;
        data  = 8'hFF;
        last  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("bp.ready", 64'(ready), 64'd0);
            checkOutput("bp.data", out_data, heldWord);
            checkOutput("bp.valid", 64'(out_valid), 64'd1);
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        checkOutput("bp.ackValid", 64'(out_valid), 64'd0);
        checkOutput("bp.ackReady", 64'(ready), 64'd1);
        tick();
        valid = 1'b0;
        expectHold("bp.ff", 64'h00000000000000FF, 1, 1'b0);
        doAck("bp");

        fillRandom(8);
        applyStimulus(1'b0, 1);
        expectHold("lenErr", modelWord(), 8, 1'b1);
        doAck("lenErr");
        fillRandom(2);
        applyStimulus(1'b1, 1);
        expectHold("afterErr", modelWord(), 2, 1'b0);
        doAck("afterErr");

        fillRandom(3);
        applyStimulus(1'b0, 0);
        reset_n = 1'b0;
        tick();
        checkResetState("midReset");
        tick();
        reset_n = 1'b1;
        tick();
        fillRandom(1);
        applyStimulus(1'b1, 0);
        expectHold("oneByte", modelWord(), 1, 1'b0);
        doAck("oneByte");

`ifdef AXIS_DESER_TIMEOUT_EN
        fillRandom(2);
        applyStimulus(1'b0, 0);
        waited = 0;
        while (!out_valid && waited < 4 * TIMEOUT_CYCLES) begin
            tick();
            waited++;
        end
        checkOutput("timeout.window",
                    64'((waited >= TIMEOUT_CYCLES) && (waited <= TIMEOUT_CYCLES + 2)), 64'd1);
        expectHold("timeout", modelWord(), 2, 1'b1);
        doAck("timeout");
`else
        fillRandom(3);
        for (int i = 0; i < 2; i++) sendByte(frameQ[i], 1'b0);
        waited = 0;
        repeat (4 * TIMEOUT_CYCLES) begin
            tick();
            if (out_valid) waited++;
        end
        checkOutput("noTimeout.idle", 64'(waited), 64'd0);
        sendByte(frameQ[2], 1'b1);
        expectHold("noTimeout", modelWord(), 3, 1'b0);
        doAck("noTimeout");
`endif

        for (int f = 0; f < 30; f++) begin
            fillRandom($urandom_range(8, 1));
            lastFinal = (frameQ.size() < 8) ? 1'b1 : 1'($urandom);
            applyStimulus(lastFinal, 3);
            heldWord = modelWord();
            expectHold("rand", heldWord, frameQ.size(), (frameQ.size() == 8) && !lastFinal);
            repeat ($urandom_range(2, 0)) begin
                valid = 1'($urandom);
                data  = 8'($urandom);
                last  = 1'($urandom);
                tick();
                checkOutput("rand.stable", out_data, heldWord);
            end
            doAck("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
